// File: rtl/axi_io_pmp_err_slv.sv
// axi_io_pmp_err_slv
//   AXI4 error-responder slave for the denied path of the AXI IO-PMP. The IO-PMP
//   sends here every transaction that fails its permission check. Each burst is
//   accepted, all of its write data is consumed, and it completes with ERR_RESP.
//   The upstream master therefore never hangs and never reaches protected memory.
//   The read and write paths are independent.
//   Each direction allows one outstanding transaction, so IDs never need reordering.
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   s_axi_aw*           write address channel (awaddr only feeds the error log)
//   s_axi_w*            write data channel (data and strobe are discarded)
//   s_axi_b*            write response channel (bid = latched awid, bresp = ERR_RESP)
//   s_axi_ar*           read address channel (araddr only feeds the error log)
//   s_axi_r*            read data channel (rdata = RDATA_FILL, rresp = ERR_RESP)
//   err_valid_o, err_addr_o, err_is_write_o, err_clr_i
//                       sticky first-fault log; these ports exist only when
//                       AXI_IO_PMP_ERR_LOG_EN is defined
//
// ADDR_WIDTH supports only 32 and 64.
// Every handshake output is a register that holds the decode of the next state.
// This keeps outputs at 0 while reset is asserted and leaves no combinational
// path from input to output.

module axi_io_pmp_err_slv #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned           ID_WIDTH   = 8,
  parameter logic [1:0]            ERR_RESP   = 2'b10,
  parameter logic [DATA_WIDTH-1:0] RDATA_FILL = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
`ifdef AXI_IO_PMP_ERR_LOG_EN
  ,
  output logic                  err_valid_o,
  output logic [ADDR_WIDTH-1:0] err_addr_o,
  output logic                  err_is_write_o,
  input  logic                  err_clr_i
`endif
);

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic       {RIdle, RData}        r_state_e;

  w_state_e            w_state_q, w_state_d;
  r_state_e            r_state_q, r_state_d;
  logic [ID_WIDTH-1:0] bid_q, bid_d;
  logic [ID_WIDTH-1:0] rid_q, rid_d;
  logic [7:0]          cnt_q, cnt_d;

  logic awready_q, awready_d;
  logic wready_q,  wready_d;
  logic bvalid_q,  bvalid_d;
  logic arready_q, arready_d;
  logic rvalid_q,  rvalid_d;
  logic rlast_q,   rlast_d;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign aw_hs = s_axi_awvalid & awready_q;
  assign w_hs  = s_axi_wvalid  & wready_q;
  assign b_hs  = bvalid_q      & s_axi_bready;
  assign ar_hs = s_axi_arvalid & arready_q;
  assign r_hs  = rvalid_q      & s_axi_rready;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      w_state_q <= WIdle;
      r_state_q <= RIdle;
      bid_q     <= '0;
      rid_q     <= '0;
      cnt_q     <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      bid_q     <= bid_d;
      rid_q     <= rid_d;
      cnt_q     <= cnt_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d = w_state_q;
    bid_d     = bid_q;
    unique case (w_state_q)
      WIdle: begin
        if (aw_hs) begin
          w_state_d = WData;
          bid_d     = s_axi_awid;
        end
      end
      // wlast alone ends the burst; awlen is not tracked
      WData:   if (w_hs && s_axi_wlast) w_state_d = WResp;
      WResp:   if (b_hs) w_state_d = WIdle;
      default: w_state_d = WIdle;
    endcase

    r_state_d = r_state_q;
    rid_d     = rid_q;
    cnt_d     = cnt_q;
    unique case (r_state_q)
      RIdle: begin
        if (ar_hs) begin
          r_state_d = RData;
          rid_d     = s_axi_arid;
          cnt_d     = s_axi_arlen;
        end
      end
      RData: begin
        if (r_hs) begin
          if (cnt_q == 8'd0) r_state_d = RIdle;
          else               cnt_d     = cnt_q - 8'd1;
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  // Output decode from next state, registered above
  always_comb begin
    awready_d = (w_state_d == WIdle);
    wready_d  = (w_state_d == WData);
    bvalid_d  = (w_state_d == WResp);
    arready_d = (r_state_d == RIdle);
    rvalid_d  = (r_state_d == RData);
    rlast_d   = (r_state_d == RData) && (cnt_d == 8'd0);
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bid     = bid_q;
  assign s_axi_bresp   = ERR_RESP;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rid     = rid_q;
  assign s_axi_rdata   = RDATA_FILL;
  assign s_axi_rresp   = ERR_RESP;

`ifdef AXI_IO_PMP_ERR_LOG_EN
  logic                  err_valid_q, err_valid_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic                  err_is_write_q, err_is_write_d;

  // Sticky first-fault capture. A clear that coincides with a new handshake
  // still logs the new fault. On a tie, the write wins.
  always_comb begin
    err_valid_d    = err_valid_q;
    err_addr_d     = err_addr_q;
    err_is_write_d = err_is_write_q;
    if (err_clr_i) err_valid_d = 1'b0;
    if (!err_valid_q || err_clr_i) begin
      if (aw_hs) begin
        err_valid_d    = 1'b1;
        err_addr_d     = s_axi_awaddr;
        err_is_write_d = 1'b1;
      end else if (ar_hs) begin
        err_valid_d    = 1'b1;
        err_addr_d     = s_axi_araddr;
        err_is_write_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_valid_q    <= 1'b0;
      err_addr_q     <= '0;
      err_is_write_q <= 1'b0;
    end else begin
      err_valid_q    <= err_valid_d;
      err_addr_q     <= err_addr_d;
      err_is_write_q <= err_is_write_d;
    end
  end

  assign err_valid_o    = err_valid_q;
  assign err_addr_o     = err_addr_q;
  assign err_is_write_o = err_is_write_q;

  logic unused_inputs;
  assign unused_inputs = ^{s_axi_wdata, s_axi_wstrb};
`else
  logic unused_inputs;
  assign unused_inputs = ^{s_axi_wdata, s_axi_wstrb, s_axi_awaddr, s_axi_araddr};
`endif

endmodule

// File: tb/tb_axi_io_pmp_err_slv.sv
// Testbench for axi_io_pmp_err_slv.
// A vector table holds the basic read and write bursts. Hand-written sequences
// cover B back-pressure, simultaneous AW/AR with mid-burst reset, and the
// optional error log.

module tb_axi_io_pmp_err_slv;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  awid = '0, arid = '0, arlen = '0;
  logic [31:0] awaddr = '0, araddr = '0, wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0, bready = 1'b0;
  logic        arvalid = 1'b0, rready = 1'b0;
  logic        awready, wready, bvalid, arready, rvalid, rlast;
  logic [7:0]  bid, rid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
`ifdef AXI_IO_PMP_ERR_LOG_EN
  logic        err_valid, err_is_write;
  logic [31:0] err_addr;
  logic        err_clr = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axi_io_pmp_err_slv dut (
    .clk           (clk),
    .rst           (rst),
    .s_axi_awid    (awid),
    .s_axi_awaddr  (awaddr),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wlast   (wlast),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bid     (bid),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_arid    (arid),
    .s_axi_araddr  (araddr),
    .s_axi_arlen   (arlen),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rid     (rid),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rlast   (rlast),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready)
`ifdef AXI_IO_PMP_ERR_LOG_EN
    ,
    .err_valid_o   (err_valid),
    .err_addr_o    (err_addr),
    .err_is_write_o(err_is_write),
    .err_clr_i     (err_clr)
`endif
  );

  typedef struct {
    logic       is_rd;
    logic [7:0] id;
    logic [7:0] len;       // W beats - 1 for writes, arlen for reads
    logic [31:0] addr;
    logic       rnd_ready;
    logic [7:0] exp_id;
    int         exp_beats;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [7:0] id, input logic [31:0] addr, input int nbeats,
                          input logic [7:0] exp_id, input int exp_beats);
    int cyc;
    int beats;
    awid    = id;
    awaddr  = addr;
    awvalid = 1'b1;
    cyc     = 0;
    while (!awready && cyc < 50) begin
      tick();
      cyc++;
    end
    chk("aw_accept", awready, 1'b1);
    tick();
    awvalid = 1'b0;
    chk("wready_latency", wready, 1'b1);
    beats = 0;
    for (int i = 0; i < nbeats; i++) begin
      wvalid = 1'b1;
      wlast  = (i == nbeats - 1);
      wdata  = $urandom;
      wstrb  = 4'hf;
      if (wready) beats++;
      tick();
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    chk("w_beats", beats, exp_beats);
    chk("bvalid_latency", bvalid, 1'b1);
    chk("bid", bid, exp_id);
    chk("bresp", bresp, 2'b10);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("b_done_bvalid_awready", {bvalid, awready}, 2'b01);
  endtask

  task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic rnd, input logic [7:0] exp_id, input int exp_beats);
    int  cyc;
    int  beats;
    int  bad;
    logic hs;
    arid    = id;
    araddr  = addr;
    arlen   = len;
    arvalid = 1'b1;
    cyc     = 0;
    while (!arready && cyc < 50) begin
      tick();
      cyc++;
    end
    chk("ar_accept", arready, 1'b1);
    tick();
    arvalid = 1'b0;
    chk("rvalid_latency", rvalid, 1'b1);
    beats = 0;
    bad   = 0;
    cyc   = 0;
    while (beats < exp_beats && cyc < 4000) begin
      rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!rvalid || arready || rid !== exp_id || rresp !== 2'b10 || rdata !== 32'h0) bad++;
      if (rlast !== (beats == exp_beats - 1)) bad++;
      hs = rready & rvalid;
      tick();
      if (hs) beats++;
      cyc++;
    end
    rready = 1'b0;
    chk("r_beats", beats, exp_beats);
    chk("r_beat_errors", bad, 0);
    chk("r_done_rvalid_rlast_arready", {rvalid, rlast, arready}, 3'b001);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int bad;
    vecs[0] = '{is_rd: 1'b0, id: 8'h5A, len: 8'd3,   addr: 32'h10, rnd_ready: 1'b0,
                exp_id: 8'h5A, exp_beats: 4};
    vecs[1] = '{is_rd: 1'b1, id: 8'h11, len: 8'd0,   addr: 32'h20, rnd_ready: 1'b0,
                exp_id: 8'h11, exp_beats: 1};
    vecs[2] = '{is_rd: 1'b1, id: 8'h22, len: 8'd255, addr: 32'h30, rnd_ready: 1'b1,
                exp_id: 8'h22, exp_beats: 256};
    vecs[3] = '{is_rd: 1'b0, id: 8'hA5, len: 8'd0,   addr: 32'h40, rnd_ready: 1'b0,
                exp_id: 8'hA5, exp_beats: 1};
    vecs[4] = '{is_rd: 1'b1, id: 8'h7F, len: 8'd3,   addr: 32'h50, rnd_ready: 1'b1,
                exp_id: 8'h7F, exp_beats: 4};

    // Reset state
    tick();
    tick();
    chk("reset_handshake_outputs", {awready, wready, bvalid, arready, rvalid, rlast}, 6'b0);
    chk("reset_ids", {bid, rid}, 16'h0);
`ifdef AXI_IO_PMP_ERR_LOG_EN
    chk("reset_log", {err_valid, err_is_write, err_addr}, 34'h0);
`endif
    rst = 1'b1;
    tick();
    chk("idle_ready", {awready, arready}, 2'b11);

    for (int v = 0; v < 5; v++) begin
      if (vecs[v].is_rd)
        do_read(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].rnd_ready,
                vecs[v].exp_id, vecs[v].exp_beats);
      else
        do_write(vecs[v].id, vecs[v].addr, int'(vecs[v].len) + 1,
                 vecs[v].exp_id, vecs[v].exp_beats);
    end

    // B back-pressure: bid stays stable and a second AW stalls
    awid = 8'h33; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    wvalid = 1'b1; wlast = 1'b1;
    tick();
    wvalid = 1'b0; wlast = 1'b0;
    awid = 8'h44; awvalid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (!bvalid || bid !== 8'h33 || awready) bad++;
      tick();
    end
    chk("b_hold_errors", bad, 0);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("aw2_ready_after_b", awready, 1'b1);
    tick();
    awvalid = 1'b0;
    chk("aw2_accepted", wready, 1'b1);
    wvalid = 1'b1; wlast = 1'b1;
    tick();
    wvalid = 1'b0; wlast = 1'b0;
    chk("aw2_bid", {bvalid, bid}, {1'b1, 8'h44});
    bready = 1'b1;
    tick();
    bready = 1'b0;

    // Simultaneous AW and AR, then reset in mid read burst
    awid = 8'h01; awvalid = 1'b1;
    arid = 8'h02; arlen = 8'd7; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; arvalid = 1'b0;
    chk("both_accepted", {wready, rvalid, awready, arready}, 4'b1100);
    rready = 1'b1;
    tick();
    tick();
    rready = 1'b0;
    chk("mid_burst", {rvalid, rlast}, 2'b10);
    rst = 1'b0;
    tick();
    chk("post_reset_outputs", {awready, wready, bvalid, arready, rvalid, rlast}, 6'b0);
    chk("post_reset_ids", {bid, rid}, 16'h0);
    rst = 1'b1;
    tick();
    chk("post_reset_idle", {awready, wready, bvalid, arready, rvalid}, 5'b10010);

`ifdef AXI_IO_PMP_ERR_LOG_EN
    chk("log_cleared_by_reset", err_valid, 1'b0);
    do_read(8'h09, 32'h8000_0000, 8'd0, 1'b0, 8'h09, 1);
    chk("log_read", {err_valid, err_is_write, err_addr}, {1'b1, 1'b0, 32'h8000_0000});
    do_write(8'h0A, 32'h0000_1000, 1, 8'h0A, 1);
    chk("log_sticky", {err_valid, err_is_write, err_addr}, {1'b1, 1'b0, 32'h8000_0000});
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("log_clear", err_valid, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
